// File: rtl/elevator_pkg.sv
// Shared state encoding and default timing constants for the elevator controllers.
package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DOWN = 2'd2,
      DOOR_OPEN = 2'd3
   } elev_state_t;

   localparam int unsigned DEF_TRAVEL_TICKS = 10_000_000;
   localparam int unsigned DEF_DOOR_TICKS   = 20_000_000;

endpackage

// File: rtl/elevator_call_scan.sv
// Combinational call scan: any pending call above/below the car, or at its floor.
module elevator_call_scan
   import elevator_pkg::*;
#(
   parameter int unsigned NUM_FLOORS = 8,
   parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
   input  logic [NUM_FLOORS-1:0] i_pending,
   input  logic [FLOOR_W-1:0]    i_current_floor,
   output logic                  o_ahead_up,
   output logic                  o_ahead_dn,
   output logic                  o_here
);

   always_comb begin
      o_ahead_up = 1'b0;
      o_ahead_dn = 1'b0;
      o_here     = 1'b0;
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
         if (i_pending[i]) begin
            if (FLOOR_W'(i) > i_current_floor)  o_ahead_up = 1'b1;
            if (FLOOR_W'(i) < i_current_floor)  o_ahead_dn = 1'b1;
            if (FLOOR_W'(i) == i_current_floor) o_here     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/elevator_scan_controller.sv
// SCAN-scheduled elevator controller with pending-call register and door dwell.
// Optional emergency stop (estop / estop_active) is built when ELEV_ESTOP_EN is defined.
module elevator_scan_controller
   import elevator_pkg::*;
#(
   parameter int unsigned NUM_FLOORS   = 8,
   parameter int unsigned FLOOR_W      = $clog2(NUM_FLOORS),
   parameter int unsigned TRAVEL_TICKS = DEF_TRAVEL_TICKS,
   parameter int unsigned DOOR_TICKS   = DEF_DOOR_TICKS,
   parameter int unsigned TMR_W        = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
`ifdef ELEV_ESTOP_EN
   input  logic                  estop,
   output logic                  estop_active,
`endif
   input  logic [NUM_FLOORS-1:0] call_req,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic                  moving_up,
   output logic                  moving_down,
   output logic                  door_open,
   output logic                  idle,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam logic [TMR_W-1:0] TRAVEL_LAST = TMR_W'(TRAVEL_TICKS - 1);
   localparam logic [TMR_W-1:0] DOOR_LAST   = TMR_W'(DOOR_TICKS - 1);

   elev_state_t             r_state, w_state_nxt;
   logic [TMR_W-1:0]        r_timer, w_timer_nxt;
   logic [FLOOR_W-1:0]      r_floor, w_floor_nxt;
   logic                    r_dir_up, w_dir_up_nxt;
   logic [NUM_FLOORS-1:0]   r_pending, w_clear;
   logic [FLOOR_W-1:0]      w_floor_up, w_floor_dn;
   logic [NUM_FLOORS-1:0]   w_cur_mask, w_up_mask, w_dn_mask;
   logic                    w_ahead_up, w_ahead_dn, w_here, w_run;

   elevator_call_scan #(
      .NUM_FLOORS (NUM_FLOORS),
      .FLOOR_W    (FLOOR_W)
   ) u_scan (
      .i_pending       (r_pending),
      .i_current_floor (r_floor),
      .o_ahead_up      (w_ahead_up),
      .o_ahead_dn      (w_ahead_dn),
      .o_here          (w_here)
   );

`ifdef ELEV_ESTOP_EN
   logic r_estop;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_estop <= 1'b0;
      else        r_estop <= estop;
   end
   assign estop_active = r_estop;
   assign w_run        = ~estop;
`else
   assign w_run = 1'b1;
`endif

   assign w_floor_up = r_floor + FLOOR_W'(1);
   assign w_floor_dn = r_floor - FLOOR_W'(1);
   assign w_cur_mask = NUM_FLOORS'(1) << r_floor;
   assign w_up_mask  = NUM_FLOORS'(1) << w_floor_up;
   assign w_dn_mask  = NUM_FLOORS'(1) << w_floor_dn;

   always_comb begin
      w_state_nxt  = r_state;
      w_timer_nxt  = r_timer + TMR_W'(1);
      w_floor_nxt  = r_floor;
      w_dir_up_nxt = r_dir_up;
      w_clear      = '0;
      unique case (r_state)
         IDLE: begin
            w_timer_nxt = '0;
            if (w_here) begin
               w_state_nxt = DOOR_OPEN;
               w_clear     = w_cur_mask;
            end else if (w_ahead_up && (r_dir_up || !w_ahead_dn)) begin
               w_state_nxt  = MOVE_UP;
               w_dir_up_nxt = 1'b1;
            end else if (w_ahead_dn) begin
               w_state_nxt  = MOVE_DOWN;
               w_dir_up_nxt = 1'b0;
            end
         end
         MOVE_UP: begin
            if (r_timer == TRAVEL_LAST) begin
               w_timer_nxt = '0;
               w_floor_nxt = w_floor_up;
               if (|(r_pending & w_up_mask)) begin
                  w_state_nxt = DOOR_OPEN;
                  w_clear     = w_up_mask;
               end
            end
         end
         MOVE_DOWN: begin
            if (r_timer == TRAVEL_LAST) begin
               w_timer_nxt = '0;
               w_floor_nxt = w_floor_dn;
               if (|(r_pending & w_dn_mask)) begin
                  w_state_nxt = DOOR_OPEN;
                  w_clear     = w_dn_mask;
               end
            end
         end
         DOOR_OPEN: begin
            // Calls for the open floor are absorbed and extend the dwell.
            w_clear = w_cur_mask;
            if (|(call_req & w_cur_mask)) begin
               w_timer_nxt = '0;
            end else if (r_timer == DOOR_LAST) begin
               w_timer_nxt = '0;
               if (r_dir_up && w_ahead_up) begin
                  w_state_nxt = MOVE_UP;
               end else if (!r_dir_up && w_ahead_dn) begin
                  w_state_nxt = MOVE_DOWN;
               end else if (w_ahead_up) begin
                  w_state_nxt  = MOVE_UP;
                  w_dir_up_nxt = 1'b1;
               end else if (w_ahead_dn) begin
                  w_state_nxt  = MOVE_DOWN;
                  w_dir_up_nxt = 1'b0;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (!w_run) begin
         w_state_nxt  = r_state;
         w_timer_nxt  = r_timer;
         w_floor_nxt  = r_floor;
         w_dir_up_nxt = r_dir_up;
         if (r_state != DOOR_OPEN) w_clear = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_timer   <= '0;
         r_floor   <= '0;
         r_dir_up  <= 1'b1;
         r_pending <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_floor   <= w_floor_nxt;
         r_dir_up  <= w_dir_up_nxt;
         r_pending <= (r_pending | call_req) & ~w_clear;
      end
   end

   assign current_floor = r_floor;
   assign pending       = r_pending;
   assign moving_up     = (r_state == MOVE_UP);
   assign moving_down   = (r_state == MOVE_DOWN);
   assign door_open     = (r_state == DOOR_OPEN);
   assign idle          = (r_state == IDLE);

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed bench for elevator_scan_controller with a cycle-level reference model.
module tb_elevator_scan_controller;

   localparam int NF       = 8;
   localparam int TRAVEL_T = 4;
   localparam int DOOR_T   = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NF-1:0] call_req;
   logic [2:0]    current_floor;
   logic          moving_up, moving_down, door_open, idle;
   logic [NF-1:0] pending;
`ifdef ELEV_ESTOP_EN
   logic          estop = 1'b0;
   logic          estop_active;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   elevator_scan_controller #(
      .NUM_FLOORS   (NF),
      .TRAVEL_TICKS (TRAVEL_T),
      .DOOR_TICKS   (DOOR_T)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
`ifdef ELEV_ESTOP_EN
      .estop         (estop),
      .estop_active  (estop_active),
`endif
      .call_req      (call_req),
      .current_floor (current_floor),
      .moving_up     (moving_up),
      .moving_down   (moving_down),
      .door_open     (door_open),
      .idle          (idle),
      .pending       (pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: car position, activity, remaining cycles in the current activity.
   localparam int A_IDLE = 0, A_UP = 1, A_DOWN = 2, A_DOOR = 3;
   int            m_floor, m_act, m_left;
   bit            m_pref_up;
   bit [NF-1:0]   m_pend;

   function automatic bit any_above(input bit [NF-1:0] p, input int f);
      for (int i = f + 1; i < NF; i++) if (p[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit any_below(input bit [NF-1:0] p, input int f);
      for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_floor = 0; m_act = A_IDLE; m_left = 0; m_pref_up = 1'b1; m_pend = '0;
      end else begin
         bit [NF-1:0] np;
         bit up, dn;
         np = m_pend | call_req;
         up = any_above(m_pend, m_floor);
         dn = any_below(m_pend, m_floor);
         case (m_act)
            A_IDLE: begin
               if (m_pend[m_floor]) begin
                  m_act = A_DOOR; m_left = DOOR_T; np[m_floor] = 1'b0;
               end else if (up && (m_pref_up || !dn)) begin
                  m_act = A_UP; m_left = TRAVEL_T; m_pref_up = 1'b1;
               end else if (dn) begin
                  m_act = A_DOWN; m_left = TRAVEL_T; m_pref_up = 1'b0;
               end
            end
            A_UP, A_DOWN: begin
               m_left--;
               if (m_left == 0) begin
                  m_floor += (m_act == A_UP) ? 1 : -1;
                  m_left = TRAVEL_T;
                  if (m_pend[m_floor]) begin
                     m_act = A_DOOR; m_left = DOOR_T; np[m_floor] = 1'b0;
                  end
               end
            end
            default: begin
               np[m_floor] = 1'b0;
               if (call_req[m_floor]) m_left = DOOR_T;
               else begin
                  m_left--;
                  if (m_left == 0) begin
                     if ((m_pref_up && up) || (!m_pref_up && !dn && up)) begin
                        m_act = A_UP; m_left = TRAVEL_T; m_pref_up = 1'b1;
                     end else if (dn) begin
                        m_act = A_DOWN; m_left = TRAVEL_T; m_pref_up = 1'b0;
                     end else m_act = A_IDLE;
                  end
               end
            end
         endcase
         m_pend = np;
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("model_floor",   32'(current_floor), 32'(m_floor));
         chk("model_up",      32'(moving_up),     32'(m_act == A_UP));
         chk("model_down",    32'(moving_down),   32'(m_act == A_DOWN));
         chk("model_door",    32'(door_open),     32'(m_act == A_DOOR));
         chk("model_idle",    32'(idle),          32'(m_act == A_IDLE));
         chk("model_pending", 32'(pending),       32'(m_pend));
      end
   end

   task automatic press(input logic [NF-1:0] v);
      call_req = v;
      @(negedge clk);
      call_req = '0;
   endtask

   task automatic wait_until_idle(input string nm);
      int n = 0;
      while (!idle && n < 100) begin @(negedge clk); n++; end
      chk(nm, 32'(idle), 32'd1);
   endtask

   initial begin
      int cnt, up_cnt, bad, rev, last_dir, n_stops;
      bit prev_door;
      int stops[3];

      rst_n = 1'b0;
      call_req = '0;
      repeat (2) @(negedge clk);
      chk("rst_floor", 32'(current_floor), 32'd0);
      chk("rst_idle",  32'(idle), 32'd1);
      chk("rst_move",  32'({moving_up, moving_down}), 32'd0);
      chk("rst_door",  32'(door_open), 32'd0);
      chk("rst_pend",  32'(pending), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Call at the current floor: 3-cycle dwell, then back to idle.
      press(8'h01);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (door_open) cnt++;
      end
      chk("t1_door_cycles", 32'(cnt), 32'd3);
      chk("t1_idle", 32'(idle), 32'd1);
      chk("t1_pend", 32'(pending), 32'd0);

      // Floor 0 -> 5: 20 moving cycles, one floor step every 4 cycles.
      press(8'h20);
      up_cnt = 0; bad = 0;
      for (int i = 0; i < 40 && !door_open; i++) begin
         if (moving_up) begin
            if (int'(current_floor) != up_cnt / TRAVEL_T) bad++;
            up_cnt++;
         end
         @(negedge clk);
      end
      chk("t2_door_reached", 32'(door_open), 32'd1);
      chk("t2_up_cycles", 32'(up_cnt), 32'd20);
      chk("t2_floor_steps", 32'(bad), 32'd0);
      chk("t2_arrive_floor", 32'(current_floor), 32'd5);
      chk("t2_pend5_clear", 32'(pending[5]), 32'd0);
      wait_until_idle("t2_idle");

      // Reset, head to 6; at floor 2 add 1 (behind) then 4 (ahead).
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      press(8'h40);
      cnt = 0;
      while (!(moving_up && current_floor == 3'd2) && cnt < 40) begin @(negedge clk); cnt++; end
      chk("t3_at_floor2", 32'(current_floor), 32'd2);
      press(8'h02);
      press(8'h10);
      n_stops = 0; rev = 0; last_dir = 0; prev_door = 1'b0;
      for (int i = 0; i < 200 && !(n_stops == 3 && idle); i++) begin
         if (door_open && !prev_door && n_stops < 3) begin
            stops[n_stops] = int'(current_floor);
            n_stops++;
         end
         if (moving_up) begin
            if (last_dir == 2) rev++;
            last_dir = 1;
         end
         if (moving_down) begin
            if (last_dir == 1) rev++;
            last_dir = 2;
         end
         prev_door = door_open;
         @(negedge clk);
      end
      chk("t3_num_stops", 32'(n_stops), 32'd3);
      chk("t3_stop0", 32'(stops[0]), 32'd4);
      chk("t3_stop1", 32'(stops[1]), 32'd6);
      chk("t3_stop2", 32'(stops[2]), 32'd1);
      chk("t3_reversals", 32'(rev), 32'd1);

      // Dwell restart: re-press the open floor on the third dwell cycle.
      press(8'h08);
      cnt = 0;
      while (!door_open && cnt < 40) begin @(negedge clk); cnt++; end
      chk("t4_door_reached", 32'(door_open), 32'd1);
      chk("t4_floor", 32'(current_floor), 32'd3);
      cnt = 1;
      @(negedge clk); if (door_open) cnt++;
      @(negedge clk); if (door_open) cnt++;
      call_req = 8'h08;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         call_req = '0;
         if (door_open) cnt++;
      end
      chk("t4_door_cycles", 32'(cnt), 32'd6);
      chk("t4_pend", 32'(pending), 32'd0);
      chk("t4_idle", 32'(idle), 32'd1);

      // Asynchronous reset while travelling 3 -> 4 with calls 6 and 7 pending.
      press(8'hC0);
      cnt = 0;
      while (!moving_up && cnt < 10) begin @(negedge clk); cnt++; end
      @(negedge clk);
      chk("t5_mid_move", 32'({moving_up, current_floor}), 32'h0B);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_floor", 32'(current_floor), 32'd0);
      chk("t5_idle", 32'(idle), 32'd1);
      chk("t5_move", 32'({moving_up, moving_down}), 32'd0);
      chk("t5_door", 32'(door_open), 32'd0);
      chk("t5_pend", 32'(pending), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_stay_idle", 32'({idle, pending}), 32'h100);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/elevator_scan_controller.md
Name: elevator_scan_controller

Overview:
Parametrised successor to the single-request elevator FSM. It latches any number of floor calls into a pending-request register and serves them using SCAN scheduling: it keeps moving in the current direction while calls exist ahead, then reverses. It adds a door-dwell phase at each served floor. It sits between the call-button decoder and the floor display / status outputs of the top level.

Parameters:
NUM_FLOORS, 8, number of floors served (2..16); floors numbered 0..NUM_FLOORS-1
FLOOR_W, $clog2(NUM_FLOORS), width of floor index
TRAVEL_TICKS, 10000000, clock cycles per one-floor move (>=2)
DOOR_TICKS, 20000000, clock cycles the door stays open (>=2)
TMR_W, 32, width of the shared phase timer; must hold max(TRAVEL_TICKS, DOOR_TICKS)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
call_req  input  NUM_FLOORS  call buttons; bit i high in a cycle registers a call for floor i
current_floor  output  FLOOR_W  floor the car is at or last passed
moving_up  output  1  state is MOVE_UP
moving_down  output  1  state is MOVE_DOWN
door_open  output  1  state is DOOR_OPEN
idle  output  1  state is IDLE
pending  output  NUM_FLOORS  registered outstanding calls

Behaviour:
- Reset is asynchronous, active-low; clock is clk. On reset: state IDLE, current_floor=0, pending=0, dir_up=1, timer=0, door_open=0, moving_up=0, moving_down=0, idle=1. A reset mid-move or mid-dwell discards all calls.
- All outputs are registered or decoded directly from state or registers.
- Every cycle: pending <= (pending | call_req) & ~clear_mask. clear_mask has only bit current_floor set when that floor is being served; otherwise it is 0. A call set in cycle N appears in pending at N+1.
- ahead_up = any pending bit above current_floor; ahead_dn = any pending bit below current_floor; here = pending[current_floor].
- IDLE:
  - here -> DOOR_OPEN (clear bit).
  - else ahead_up -> MOVE_UP.
  - else ahead_dn -> MOVE_DOWN.
  - If both ahead_up and ahead_dn, take the dir_up preference.
- MOVE_UP / MOVE_DOWN:
  - timer counts 0..TRAVEL_TICKS-1.
  - At TRAVEL_TICKS-1, current_floor is incremented/decremented and timer goes to 0.
  - If pending[new floor] is set -> DOOR_OPEN, and the bit clears in the same cycle as door_open rises.
  - Else continue in the same direction.
  - The car never passes floor 0 or NUM_FLOORS-1: a move is only started when a call exists ahead.
- DOOR_OPEN:
  - Held for DOOR_TICKS cycles.
  - A call for current_floor during dwell is cleared immediately and restarts the dwell timer at 0.
  - On expiry:
    - ahead in dir_up direction -> move that way.
    - else ahead in the opposite direction -> reverse and toggle dir_up.
    - else -> IDLE.
- dir_up updates to 1 on entering MOVE_UP and to 0 on entering MOVE_DOWN.
- A call arriving for a floor the car is mid-travel toward is served on arrival.
- Calls behind the car wait until reversal.
- The timer resets to 0 on every state change.

Optional Feature:
ELEV_ESTOP_EN:
- With the macro defined, an input port estop (1 bit) is added.
  - While estop=1 the state and timer freeze, and calls still latch into pending.
  - If the car is in DOOR_OPEN, door_open stays 1.
  - A new output estop_active mirrors registered estop.
  - On release, operation resumes from the frozen timer value.
- Without the macro, neither port exists and behaviour is as above.

Decomposition:
- Package elevator_pkg: state encoding constants (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN as a 2-bit typedef) and the default tick constants.
- One sub-module, elevator_call_scan: purely combinational. It takes pending and current_floor and produces ahead_up, ahead_dn and here. It is reused by the future multi-car dispatcher.

Test Plan (NUM_FLOORS=8, TRAVEL_TICKS=4, DOOR_TICKS=3):
- Reset then call_req=8'b0000_0001 for 1 cycle at floor 0 -> door_open=1 on the following cycle for 3 cycles, then idle=1, pending=0.
- call floor 5 from floor 0 -> moving_up is high for 20 cycles and current_floor steps 1..5, one step every 4 cycles; door_open rises in the same cycle as current_floor=5 and pending[5] clears.
- At floor 2 moving up with pending {1,6}, add call 4 -> stops at 4 then 6, then reverses and stops at 1; dir_up toggles once.
- During dwell at floor 3, press call 3 at dwell cycle 2 -> dwell restarts and the door is open for 3 more cycles.
- Assert rst_n low while moving between floors 3->4 with pending {6,7} -> all outputs are at reset values immediately (async) and pending=0.
- With ELEV_ESTOP_EN, estop high for 10 cycles mid-travel -> current_floor and timer hold; calls latch; arrival is delayed exactly 10 cycles.
